mdu: RTL and testbench

Multiply/divide unit for the five-stage MIPS pipeline. Sits beside the ALU in the EX stage and takes the same latched rs/rt operands from the ID/EX register. Runs MULT/MULTU/DIV/DIVU as multi-cycle operations into private HI/LO registers, and handles MTHI/MTLO in a single cycle. The hazard logic reads `busy` to stall MFHI/MFLO and any new multiply/divide until the result is ready; writeback reads `hi`/`lo` directly.

---
 rtl/mdu.sv | 165 ++++++++++++++++
 tb/tb_mdu.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with private HI/LO registers for the EX stage.
// Define MDU_DIV_EN to build the divider (DIV/DIVU, DIV and FIX states, dz flag).
module mdu #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dz
);

  localparam int         DATA_W   = 32;
  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t                     state, state_nxt;
  logic [4:0]                 cnt;
  logic                       issue, is_mul;
  logic signed [DATA_W-1:0]   a_p0, b_p0;
  logic                       sgn_p0;
  logic signed [2*DATA_W-1:0] mul_x, mul_y, prod;

  assign issue  = start && (state == S_IDLE);
  assign is_mul = (op[2:1] == 2'b00);
  assign busy   = (state != S_IDLE);

`ifdef MDU_DIV_EN
  logic                is_div;
  logic [DATA_W-1:0]   quo_p1, rem_p1, sub, q_fix, r_fix;
  logic [DATA_W:0]     dvs_p1, mag_a, mag_b, shifted;
  logic                ge, dz_q;

  // 33-bit magnitude so that |-2^31| is representable
  function automatic logic [DATA_W:0] mag33(input logic sgn, input logic [DATA_W-1:0] x);
    logic [DATA_W:0] ext;
    ext = {sgn & x[DATA_W-1], x};
    return ext[DATA_W] ? (33'd0 - ext) : ext;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic neg, input logic [DATA_W-1:0] m);
    return neg ? (32'd0 - m) : m;
  endfunction

  assign is_div = (op[2:1] == 2'b01);

  always_comb begin
    mag_a   = mag33(~op[0], a);
    mag_b   = mag33(~op[0], b);
    shifted = {rem_p1, quo_p1[DATA_W-1]};
    ge      = (shifted >= dvs_p1);
    // when ge holds the true difference is below 2^32, so 32-bit subtraction is exact
    sub     = shifted[DATA_W-1:0] - dvs_p1[DATA_W-1:0];
    q_fix   = apply_sign(sgn_p0 && (a_p0[DATA_W-1] ^ b_p0[DATA_W-1]), quo_p1);
    r_fix   = apply_sign(sgn_p0 && a_p0[DATA_W-1], rem_p1);
  end

  // stage p1: restoring divider, one quotient bit per cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_p1 <= '0;
      rem_p1 <= '0;
      dvs_p1 <= '0;
    end else if (issue) begin
      quo_p1 <= mag_a[DATA_W-1:0];
      rem_p1 <= {31'd0, mag_a[DATA_W]};
      dvs_p1 <= mag_b;
    end else if (state == S_DIV) begin
      quo_p1 <= {quo_p1[DATA_W-2:0], ge};
      rem_p1 <= ge ? sub : shifted[DATA_W-1:0];
    end
  end

  assign dz = dz_q;
`else
  assign dz = 1'b0;
`endif

  always_comb begin
    mul_x = {{DATA_W{sgn_p0 & a_p0[DATA_W-1]}}, a_p0};
    mul_y = {{DATA_W{sgn_p0 & b_p0[DATA_W-1]}}, b_p0};
    prod  = mul_x * mul_y;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (issue) begin
          if (is_mul) state_nxt = S_MUL;
`ifdef MDU_DIV_EN
          else if (is_div) state_nxt = (b == '0) ? S_FIX : S_DIV;
`endif
        end
      end
      S_MUL: if (cnt == '0) state_nxt = S_IDLE;
`ifdef MDU_DIV_EN
      S_DIV: if (cnt == '0) state_nxt = S_FIX;
      S_FIX: state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (issue) cnt <= is_mul ? MUL_LAST : DIV_LAST;
    else if ((state == S_MUL || state == S_DIV) && cnt != '0) cnt <= cnt - 5'd1;
  end

  // stage p0: operands captured at issue, held for the whole operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_p0   <= '0;
      b_p0   <= '0;
      sgn_p0 <= 1'b0;
    end else if (issue) begin
      a_p0   <= a;
      b_p0   <= b;
      sgn_p0 <= ~op[0];
    end
  end

  // result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
`ifdef MDU_DIV_EN
      dz_q <= 1'b0;
`endif
    end else begin
      if (issue && op == OP_MTHI) hi <= a;
      if (issue && op == OP_MTLO) lo <= a;
      if (state == S_MUL && cnt == '0) {hi, lo} <= prod;
`ifdef MDU_DIV_EN
      if (state == S_FIX) begin
        if (dvs_p1 == '0) begin
          lo   <= '1;
          hi   <= a_p0;
          dz_q <= 1'b1;
        end else begin
          lo <= q_fix;
          hi <= r_fix;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed, table-driven bench for mdu; expectations adapt to whether MDU_DIV_EN is defined.
module tb_mdu;

`ifdef MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;
  logic        dz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[12];

  mdu #(.MUL_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issue one op at E0, scramble the operands afterwards, then count busy cycles.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int cyc);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = OP_NOP; a = $urandom; b = $urandom;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 4, 1'b0};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,
                 DIV_ON ? 32'hFFFFFFFF : 32'hFFFFFFFE, DIV_ON ? 32'hFFFFFFFD : 32'h1,
                 DIV_ON ? 33 : 0, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,
                 DIV_ON ? 32'd2 : 32'hFFFFFFFE, DIV_ON ? 32'd14 : 32'h1, DIV_ON ? 33 : 0, 1'b0};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF,
                 DIV_ON ? 32'h0 : 32'hFFFFFFFE, DIV_ON ? 32'h80000000 : 32'h1,
                 DIV_ON ? 33 : 0, 1'b0};
    vecs[5]  = '{OP_DIVU,  32'd5,        32'd0,
                 DIV_ON ? 32'd5 : 32'hFFFFFFFE, DIV_ON ? 32'hFFFFFFFF : 32'h1,
                 DIV_ON ? 1 : 0, DIV_ON};
    vecs[6]  = '{OP_MTHI,  32'hCAFEF00D, 32'h0,
                 32'hCAFEF00D, DIV_ON ? 32'hFFFFFFFF : 32'h1, 0, DIV_ON};
    vecs[7]  = '{OP_MTLO,  32'h00001234, 32'h0,        32'hCAFEF00D, 32'h00001234, 0, DIV_ON};
    vecs[8]  = '{OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 4, DIV_ON};
    vecs[9]  = '{OP_MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 4, DIV_ON};
    vecs[10] = '{OP_DIV,   32'd7,        32'hFFFFFFFE,
                 32'h1, DIV_ON ? 32'hFFFFFFFD : 32'h0, DIV_ON ? 33 : 0, DIV_ON};
    vecs[11] = '{OP_NOP,   32'hDEADBEEF, 32'h1,
                 32'h1, DIV_ON ? 32'hFFFFFFFD : 32'h0, 0, DIV_ON};

    reset = 1'b0; start = 1'b0; op = OP_MULT; a = 32'h5; b = 32'h7;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_dz", {31'd0, dz}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      chk($sformatf("vec%0d_busy_cycles", i), cyc, vecs[i].exp_cyc);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      chk($sformatf("vec%0d_dz", i), {31'd0, dz}, {31'd0, vecs[i].exp_dz});
    end

    // Re-issue during busy is ignored; start on the falling edge of busy is ignored too.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd3;
    @(negedge clk);
    op = OP_MULTU; a = 32'd10; b = 32'd10;
    chk("reissue_busy_e0", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reissue_busy_e3", {31'd0, busy}, 32'd1);
    start = 1'b1; op = OP_MTLO; a = 32'h0000BEEF;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    chk("reissue_busy_e4", {31'd0, busy}, 32'd0);
    chk("reissue_lo", lo, 32'd6);
    chk("reissue_hi", hi, 32'd0);

    @(negedge clk);
    start = 1'b1; op = OP_MTLO; a = 32'h00001234;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    chk("mtlo_lo", lo, 32'h00001234);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; op = DIV_ON ? OP_DIVU : OP_MULT; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    repeat (DIV_ON ? 9 : 2) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_dz", {31'd0, dz}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(OP_MULTU, 32'd4, 32'd5, cyc);
    chk("post_reset_cycles", cyc, 32'd4);
    chk("post_reset_lo", lo, 32'd20);
    chk("post_reset_hi", hi, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
